// File: rtl/avalon_arbiter.sv
// Two-master round-robin arbiter in front of one shared Avalon-MM slave.
// Master 0 is instruction fetch and master 1 is the data port. The slave command passes straight through from the granted master.
module avalon_arbiter #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [3:0]        m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [31:0]       m0_writedata,
    output logic [31:0]       m0_readdata,
    output logic              m0_waitrequest,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [3:0]        m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [31:0]       m1_writedata,
    output logic [31:0]       m1_readdata,
    output logic              m1_waitrequest,

    output logic [ADDR_W-1:0] s_address,
    output logic [3:0]        s_byteenable,
    output logic              s_read,
    output logic              s_write,
    output logic [31:0]       s_writedata,
    input  logic [31:0]       s_readdata,
    input  logic              s_waitrequest,

    output logic [CNT_W-1:0]  grant_count0,
    output logic [CNT_W-1:0]  grant_count1
);

    // state   | meaning
    // IDLE    | no master granted, slave command idle
    // BUSY0   | master 0 owns the slave
    // BUSY1   | master 1 owns the slave
    typedef enum logic [1:0] {S_IDLE, S_BUSY0, S_BUSY1} state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt0_q, cnt0_d;
    logic [CNT_W-1:0]   cnt1_q, cnt1_d;
    logic               m0_req, m1_req;

    assign m0_req = m0_read | m0_write;
    assign m1_req = m1_read | m1_write;

    // On a tie the grant goes to the master that did not complete last.
    function automatic state_t pick(input logic r0, input logic r1, input logic lg);
        if (r0 && r1)
            return lg ? S_BUSY0 : S_BUSY1;
        else if (r0)
            return S_BUSY0;
        else if (r1)
            return S_BUSY1;
        else
            return S_IDLE;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        case (state_q)
            S_IDLE: begin
                state_d = pick(m0_req, m1_req, last_grant_q);
            end
            S_BUSY0: begin
                if (!m0_req) begin
                    state_d = S_IDLE;
                end else if (!s_waitrequest) begin
                    last_grant_d = 1'b0;
                    cnt0_d       = cnt0_q + CNT_W'(1);
                    state_d      = pick(m0_req, m1_req, 1'b0);
                end
            end
            S_BUSY1: begin
                if (!m1_req) begin
                    state_d = S_IDLE;
                end else if (!s_waitrequest) begin
                    last_grant_d = 1'b1;
                    cnt1_d       = cnt1_q + CNT_W'(1);
                    state_d      = pick(m0_req, m1_req, 1'b1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset forces IDLE, so these defaults also define the in-reset outputs.
    always_comb begin
        s_address      = '0;
        s_byteenable   = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        m0_readdata    = '0;
        m1_readdata    = '0;
        m0_waitrequest = m0_req;
        m1_waitrequest = m1_req;
        case (state_q)
            S_BUSY0: begin
                s_address      = m0_address;
                s_byteenable   = m0_byteenable;
                s_read         = m0_read;
                s_write        = m0_write;
                s_writedata    = m0_writedata;
                m0_readdata    = s_readdata;
                m0_waitrequest = m0_req & s_waitrequest;
            end
            S_BUSY1: begin
                s_address      = m1_address;
                s_byteenable   = m1_byteenable;
                s_read         = m1_read;
                s_write        = m1_write;
                s_writedata    = m1_writedata;
                m1_readdata    = s_readdata;
                m1_waitrequest = m1_req & s_waitrequest;
            end
            default: ;
        endcase
    end

    assign grant_count0 = cnt0_q;
    assign grant_count1 = cnt1_q;

endmodule

// File: tb/tb_avalon_arbiter.sv
// Directed bench for avalon_arbiter with a 2-bit grant counter, so counter wrap is exercised.
// Each step is a hand-computed expectation checked by an immediate assertion.
module tb_avalon_arbiter;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] m0_address, m1_address, s_address;
    logic [3:0]        m0_byteenable, m1_byteenable, s_byteenable;
    logic              m0_read, m0_write, m1_read, m1_write, s_read, s_write;
    logic [31:0]       m0_writedata, m1_writedata, s_writedata;
    logic [31:0]       m0_readdata, m1_readdata, s_readdata;
    logic              m0_waitrequest, m1_waitrequest, s_waitrequest;
    logic [CNT_W-1:0]  grant_count0, grant_count1;

    int n_vec = 0;
    int n_err = 0;

    avalon_arbiter #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_readdata(m0_readdata),
        .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_readdata(m1_readdata),
        .m1_waitrequest(m1_waitrequest),
        .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read),
        .s_write(s_write), .s_writedata(s_writedata), .s_readdata(s_readdata),
        .s_waitrequest(s_waitrequest),
        .grant_count0(grant_count0), .grant_count1(grant_count1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        m0_address = '0; m0_byteenable = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0;
        m1_address = '0; m1_byteenable = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0;
        s_readdata = '0; s_waitrequest = 1'b1;
        #1;
        chk("rst_s_read", s_read, 0);
        chk("rst_cnt0", grant_count0, 0);
        chk("rst_cnt1", grant_count1, 0);
        // Requests during reset: no slave activity, waitrequest mirrors request
        m0_read = 1'b1; m0_address = 32'h44; s_readdata = 32'hFFFF_0000;
        #1;
        chk("rst_m0_wait", m0_waitrequest, 1);
        chk("rst_m1_wait", m1_waitrequest, 0);
        chk("rst_s_addr", s_address, 0);
        chk("rst_s_read_req", s_read, 0);
        chk("rst_m0_rdata", m0_readdata, 0);
        m0_read = 1'b0; s_readdata = '0;
        #6 reset_n = 1'b1;

        // Single read with 4 wait cycles
        tick();
        m0_read = 1'b1; m0_address = 32'h100; m0_byteenable = 4'hF; s_waitrequest = 1'b1;
        #1;
        chk("rd_idle_s_read", s_read, 0);
        chk("rd_idle_wait", m0_waitrequest, 1);
        tick();
        chk("rd_busy_s_read", s_read, 1);
        chk("rd_busy_s_addr", s_address, 32'h100);
        chk("rd_busy_wait", m0_waitrequest, 1);
        tick(); tick(); tick();
        chk("rd_wait4", m0_waitrequest, 1);
        s_waitrequest = 1'b0; s_readdata = 32'hDEAD_BEEF;
        #1;
        chk("rd_rdata", m0_readdata, 32'hDEAD_BEEF);
        chk("rd_done_wait", m0_waitrequest, 0);
        chk("rd_cnt0_pre", grant_count0, 0);
        tick();
        chk("rd_cnt0", grant_count0, 1);
        m0_read = 1'b0; s_waitrequest = 1'b1;
        #1;
        chk("rd_drop_s_read", s_read, 0);
        tick();
        chk("rd_idle_cnt0", grant_count0, 1);

        // Tie from reset: m0 first, then alternate back-to-back
        reset_pulse();
        chk("tie_rst_cnt0", grant_count0, 0);
        m0_read = 1'b1; m0_address = 32'h10; m1_read = 1'b1; m1_address = 32'h20;
        s_waitrequest = 1'b0; s_readdata = 32'hA5;
        tick();
        chk("tie_b0_addr", s_address, 32'h10);
        chk("tie_b0_w0", m0_waitrequest, 0);
        chk("tie_b0_w1", m1_waitrequest, 1);
        chk("tie_b0_rd0", m0_readdata, 32'hA5);
        chk("tie_b0_rd1", m1_readdata, 0);
        tick();
        chk("tie1_cnt0", grant_count0, 1);
        chk("tie1_cnt1", grant_count1, 0);
        chk("tie1_addr", s_address, 32'h20);
        chk("tie1_w0", m0_waitrequest, 1);
        chk("tie1_w1", m1_waitrequest, 0);
        tick();
        chk("tie2_cnt0", grant_count0, 1);
        chk("tie2_cnt1", grant_count1, 1);
        chk("tie2_addr", s_address, 32'h10);
        tick();
        chk("tie3_cnt0", grant_count0, 2);
        chk("tie3_cnt1", grant_count1, 1);
        m0_read = 1'b0; m1_read = 1'b0;
        #1;
        chk("tie_drop_s_read", s_read, 0);
        tick();
        chk("tie_end_cnt1", grant_count1, 1);

        // Write passthrough for m1 (last grant was m0) while m0 waits
        m1_write = 1'b1; m1_address = 32'h200; m1_byteenable = 4'b0011; m1_writedata = 32'h1234_5678;
        m0_read = 1'b1; m0_address = 32'h10; m0_byteenable = 4'hF; s_waitrequest = 1'b1;
        #1;
        chk("wr_idle_s_write", s_write, 0);
        chk("wr_idle_s_wdata", s_writedata, 0);
        tick();
        chk("wr_s_write", s_write, 1);
        chk("wr_s_read", s_read, 0);
        chk("wr_s_addr", s_address, 32'h200);
        chk("wr_s_be", s_byteenable, 32'h3);
        chk("wr_s_wdata", s_writedata, 32'h1234_5678);
        chk("wr_w0", m0_waitrequest, 1);
        chk("wr_w1", m1_waitrequest, 1);
        s_waitrequest = 1'b0;
        #1;
        chk("wr_done_w1", m1_waitrequest, 0);
        chk("wr_done_w0", m0_waitrequest, 1);
        tick();
        chk("wr_cnt1", grant_count1, 2);
        m1_write = 1'b0;
        #1;
        chk("wr_m0_addr", s_address, 32'h10);
        chk("wr_m0_s_write", s_write, 0);
        chk("wr_m0_s_read", s_read, 1);
        tick();
        chk("wr_cnt0", grant_count0, 3);
        m0_read = 1'b0; s_waitrequest = 1'b1;
        tick();

        // Abort during BUSY1: no count, last grant unchanged (m0 last)
        m1_write = 1'b1;
        tick();
        chk("ab_s_write", s_write, 1);
        m1_write = 1'b0;
        #1;
        chk("ab_drop_s_write", s_write, 0);
        chk("ab_drop_w1", m1_waitrequest, 0);
        tick();
        chk("ab_cnt1", grant_count1, 2);
        chk("ab_idle_s_write", s_write, 0);
        m0_read = 1'b1; m1_read = 1'b1;
        tick();
        chk("ab_tie_addr", s_address, 32'h200);
        m0_read = 1'b0; m1_read = 1'b0;
        tick();
        chk("ab_tie_cnt1", grant_count1, 2);

        // Async reset in the middle of BUSY0
        m0_read = 1'b1; m0_address = 32'h100;
        tick();
        chk("ar_s_read", s_read, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_s_read_rst", s_read, 0);
        chk("ar_cnt0", grant_count0, 0);
        chk("ar_cnt1", grant_count1, 0);
        chk("ar_w0", m0_waitrequest, 1);
        #2 reset_n = 1'b1;
        #1;
        chk("ar_idle_s_read", s_read, 0);
        tick();
        chk("ar_re_s_read", s_read, 1);
        s_waitrequest = 1'b0;
        #1;
        chk("ar_re_w0", m0_waitrequest, 0);
        tick();
        chk("ar_re_cnt0", grant_count0, 1);
        m0_read = 1'b0; s_waitrequest = 1'b1;
        tick();

        // Counter wrap: five completions on a 2-bit counter
        reset_pulse();
        m0_read = 1'b1; s_waitrequest = 1'b0;
        tick();
        chk("wrap_start", grant_count0, 0);
        tick(); chk("wrap_1", grant_count0, 1);
        tick(); chk("wrap_2", grant_count0, 2);
        tick(); chk("wrap_3", grant_count0, 3);
        tick(); chk("wrap_4", grant_count0, 0);
        tick(); chk("wrap_5", grant_count0, 1);
        chk("wrap_cnt1", grant_count1, 0);
        m0_read = 1'b0; s_waitrequest = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
